// File: rtl/fma16_norm_if.sv
// Handshake and data bundle between the fma16 add stage, the normalization stage and the rounding stage.
// slave is the normalization stage side; master is the upstream/downstream environment side.
`timescale 1ns/1ps
interface fma16_norm_if;
    logic        in_valid;
    logic        in_ready;
    logic        As;
    logic [6:0]  Ae;
    logic [36:0] Am;
    logic        AStickyIn;
    logic [1:0]  RndModeIn;
    logic        out_valid;
    logic        out_ready;
    logic        Ss;
    logic [6:0]  Se;
    logic [35:0] Sm;
    logic        ASticky;
    logic [1:0]  RndMode;

    modport slave (
        input  in_valid, As, Ae, Am, AStickyIn, RndModeIn, out_ready,
        output in_ready, out_valid, Ss, Se, Sm, ASticky, RndMode
    );

    modport master (
        output in_valid, As, Ae, Am, AStickyIn, RndModeIn, out_ready,
        input  in_ready, out_valid, Ss, Se, Sm, ASticky, RndMode
    );
endinterface

// File: rtl/fma16_norm.sv
// fma16 normalization stage: leading-one detect and shift of the signed-magnitude sum, valid/ready pipelined.
// Define FMA16_NORM_PIPE2_EN for the two-stage (LZC | shift) pipeline; otherwise one registered stage.
`timescale 1ns/1ps
module fma16_norm (
    input  logic          clk,
    input  logic          reset,
    fma16_norm_if.slave   bus
);

    function automatic logic [5:0] lzc36(input logic [35:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 35; i >= 0; i--) begin
            if (found) begin
                found = 1'b1;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + 6'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [35:0] norm_mant(input logic [36:0] m, input logic [5:0] lz,
                                              input logic carry, input logic zero);
        if (carry) begin
            return m[36:1];
        end else if (zero) begin
            return 36'd0;
        end else begin
            return m[35:0] << lz;
        end
    endfunction

    // Exponent wraps modulo 128; range checking is left to the rounding stage.
    function automatic logic [6:0] norm_exp(input logic [6:0] e, input logic [5:0] lz,
                                            input logic carry, input logic zero);
        if (carry) begin
            return e + 7'd1;
        end else if (zero) begin
            return 7'd0;
        end else begin
            return e - {1'b0, lz};
        end
    endfunction

    logic        out_valid_r;
    logic        ss_r;
    logic [6:0]  se_r;
    logic [35:0] sm_r;
    logic        sticky_r;
    logic [1:0]  rnd_r;
    logic        in_ready_s;

`ifdef FMA16_NORM_PIPE2_EN
    logic        s1_valid_r;
    logic        s1_s_r;
    logic [6:0]  s1_e_r;
    logic [36:0] s1_m_r;
    logic        s1_st_r;
    logic [1:0]  s1_rm_r;
    logic [5:0]  s1_lz_r;
    logic        s1_carry_r;
    logic        s1_zero_r;
    logic        s1_advance_s;
    logic        s2_load_s;

    // Stage advance: stage 2 frees when empty or drained; stage 1 moves when stage 2 frees.
    always_comb begin
        s2_load_s    = !out_valid_r | bus.out_ready;
        s1_advance_s = s1_valid_r & s2_load_s;
        in_ready_s   = !s1_valid_r | s1_advance_s;
    end

    // Stage 1: capture operands with leading-zero count and carry/zero classification.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_s_r     <= 1'b0;
            s1_e_r     <= 7'd0;
            s1_m_r     <= 37'd0;
            s1_st_r    <= 1'b0;
            s1_rm_r    <= 2'd0;
            s1_lz_r    <= 6'd0;
            s1_carry_r <= 1'b0;
            s1_zero_r  <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_s_r     <= bus.As;
                s1_e_r     <= bus.Ae;
                s1_m_r     <= bus.Am;
                s1_st_r    <= bus.AStickyIn;
                s1_rm_r    <= bus.RndModeIn;
                s1_lz_r    <= lzc36(bus.Am[35:0]);
                s1_carry_r <= bus.Am[36];
                s1_zero_r  <= (bus.Am == 37'd0);
            end
        end
    end

    // Stage 2 / output register: apply the shift and exponent adjust.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            ss_r        <= 1'b0;
            se_r        <= 7'd0;
            sm_r        <= 36'd0;
            sticky_r    <= 1'b0;
            rnd_r       <= 2'd0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                ss_r     <= s1_s_r;
                se_r     <= norm_exp(s1_e_r, s1_lz_r, s1_carry_r, s1_zero_r);
                sm_r     <= norm_mant(s1_m_r, s1_lz_r, s1_carry_r, s1_zero_r);
                sticky_r <= s1_st_r | (s1_carry_r & s1_m_r[0]);
                rnd_r    <= s1_rm_r;
            end
        end
    end
`else
    logic [5:0]  lz_s;
    logic        carry_s;
    logic        zero_s;

    // Single stage: classify the incoming sum and decide whether the output register may load.
    always_comb begin
        lz_s       = lzc36(bus.Am[35:0]);
        carry_s    = bus.Am[36];
        zero_s     = (bus.Am == 37'd0);
        in_ready_s = !out_valid_r | bus.out_ready;
    end

    // Output register: full normalization in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            ss_r        <= 1'b0;
            se_r        <= 7'd0;
            sm_r        <= 36'd0;
            sticky_r    <= 1'b0;
            rnd_r       <= 2'd0;
        end else if (in_ready_s) begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                ss_r     <= bus.As;
                se_r     <= norm_exp(bus.Ae, lz_s, carry_s, zero_s);
                sm_r     <= norm_mant(bus.Am, lz_s, carry_s, zero_s);
                sticky_r <= bus.AStickyIn | (carry_s & bus.Am[0]);
                rnd_r    <= bus.RndModeIn;
            end
        end
    end
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.Ss        = ss_r;
    assign bus.Se        = se_r;
    assign bus.Sm        = sm_r;
    assign bus.ASticky   = sticky_r;
    assign bus.RndMode   = rnd_r;

endmodule

// File: tb/tb_fma16_norm.sv
// Self-checking bench for fma16_norm: directed vector table, handshake corner sequences and a randomized
// scoreboard run against an iterative normalize-by-shifting reference model.
`timescale 1ns/1ps
module tb_fma16_norm;

`ifdef FMA16_NORM_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic        s;
        logic [6:0]  e;
        logic [36:0] m;
        logic        st;
        logic [1:0]  rm;
    } in_t;

    typedef struct packed {
        logic        s;
        logic [6:0]  e;
        logic [35:0] m;
        logic        st;
        logic [1:0]  rm;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fma16_norm_if bus();

    fma16_norm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   tests = 0;
    int   fails = 0;
    out_t q[$];
    in_t  cur_in;
    logic last_acc;
    logic last_out;
    vec_t tbl[7];

    // Reference: shift left one place at a time until the leading one reaches bit 35.
    function automatic out_t model(input in_t x);
        out_t        r;
        logic [35:0] m;
        logic [6:0]  e;
        r.s  = x.s;
        r.rm = x.rm;
        if (x.m[36]) begin
            r.m  = x.m[36:1];
            r.e  = x.e + 7'd1;
            r.st = x.st | x.m[0];
        end else if (x.m == 37'd0) begin
            r.m  = 36'd0;
            r.e  = 7'd0;
            r.st = x.st;
        end else begin
            m = x.m[35:0];
            e = x.e;
            while (!m[35]) begin
                m = m << 1;
                e = e - 7'd1;
            end
            r.m  = m;
            r.e  = e;
            r.st = x.st;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic s, input logic [6:0] e, input logic [36:0] m, input logic st,
                                input logic [1:0] rm, input logic [6:0] oe, input logic [35:0] om, input logic ost);
        vec_t v;
        v.i = '{s: s, e: e, m: m, st: st, rm: rm};
        v.o = '{s: s, e: oe, m: om, st: ost, rm: rm};
        return v;
    endfunction

    function automatic out_t sample();
        out_t r;
        r.s  = bus.Ss;
        r.e  = bus.Se;
        r.m  = bus.Sm;
        r.st = bus.ASticky;
        r.rm = bus.RndMode;
        return r;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input out_t act, input out_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got s=%b e=%0d m=%h st=%b rm=%0d, expected s=%b e=%0d m=%h st=%b rm=%0d",
                     name, act.s, act.e, act.m, act.st, act.rm, exp.s, exp.e, exp.m, exp.st, exp.rm);
        end
    endtask

    task automatic drive(input in_t x, input logic v);
        cur_in        = x;
        bus.in_valid  = v;
        bus.As        = x.s;
        bus.Ae        = x.e;
        bus.Am        = x.m;
        bus.AStickyIn = x.st;
        bus.RndModeIn = x.rm;
    endtask

    // One clock of scoreboard traffic with the inputs currently driven.
    task automatic cycle();
        logic exp_rdy;
        @(negedge clk);
        if (q.size() == 0) check1("idle_out_valid", bus.out_valid, 1'b0);
        exp_rdy = (q.size() < LAT) || bus.out_ready;
        check1("in_ready", bus.in_ready, exp_rdy);
        last_out = bus.out_valid & bus.out_ready;
        if (last_out && q.size() > 0) checkw("result", sample(), q.pop_front());
        last_acc = bus.in_valid & bus.in_ready;
        if (last_acc) q.push_back(model(cur_in));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        out_t zero_o;
        zero_o = '0;
        check1({name, "_out_valid"}, bus.out_valid, 1'b0);
        check1({name, "_in_ready"}, bus.in_ready, 1'b1);
        checkw({name, "_outputs"}, sample(), zero_o);
    endtask

    initial begin
        in_t x;
        int  idx;
        int  nout;
        int  first_c;
        int  last_c;

        tbl[0] = mk(1'b0, 7'd15,  37'h10_0000_0001, 1'b0, 2'd1, 7'd16, 36'h8_0000_0000, 1'b1);
        tbl[1] = mk(1'b1, 7'd30,  37'h00_0000_1000, 1'b1, 2'd2, 7'd7,  36'h8_0000_0000, 1'b1);
        tbl[2] = mk(1'b1, 7'd20,  37'h00_0000_0000, 1'b1, 2'd3, 7'd0,  36'h0_0000_0000, 1'b1);
        tbl[3] = mk(1'b0, 7'd2,   37'h00_0000_0001, 1'b0, 2'd0, 7'd95, 36'h8_0000_0000, 1'b0);
        tbl[4] = mk(1'b0, 7'd100, 37'h0F_0000_0003, 1'b0, 2'd1, 7'd100, 36'hF_0000_0003, 1'b0);
        tbl[5] = mk(1'b1, 7'd127, 37'h1F_FFFF_FFFE, 1'b0, 2'd2, 7'd0,  36'hF_FFFF_FFFF, 1'b0);
        tbl[6] = mk(1'b0, 7'd64,  37'h00_0300_0000, 1'b1, 2'd3, 7'd54, 36'hC_0000_0000, 1'b1);

        reset         = 1'b1;
        bus.out_ready = 1'b0;
        drive('0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;

        // Directed vectors, one at a time, with exact latency.
        bus.out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            drive(tbl[v].i, 1'b1);
            @(negedge clk);
            check1("tbl_in_ready", bus.in_ready, 1'b1);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            for (int k = 1; k <= LAT; k++) begin
                if (k > 1) @(posedge clk);
                @(negedge clk);
                if (k < LAT) check1("tbl_early_valid", bus.out_valid, 1'b0);
            end
            check1("tbl_valid", bus.out_valid, 1'b1);
            checkw("tbl_data", sample(), tbl[v].o);
            @(posedge clk);
            #1;
        end

        // Backpressure: four back-to-back offers, downstream stalled for five cycles.
        q.delete();
        idx = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(tbl[idx].i, idx < 4);
            cycle();
            if (last_acc) idx++;
        end
        tests++;
        if (idx != LAT) begin
            fails++;
            $display("FAIL bp_accepted: got %0d inputs accepted while stalled, expected %0d", idx, LAT);
        end
        drive(tbl[idx].i, 1'b1);
        check1("bp_in_ready_low", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        nout = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 12; c++) begin
            drive(tbl[(idx < 4) ? idx : 0].i, idx < 4);
            cycle();
            if (last_acc) idx++;
            if (last_out) begin
                nout++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        tests++;
        if (nout != 4 || (last_c - first_c) != 3) begin
            fails++;
            $display("FAIL bp_drain: got %0d results over %0d cycles, expected 4 over 4", nout, last_c - first_c + 1);
        end

        // Reset with entries in flight.
        q.delete();
        bus.out_ready = 1'b0;
        drive(tbl[4].i, 1'b1);
        cycle();
        drive(tbl[5].i, 1'b1);
        cycle();
        drive('0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        @(negedge clk);
        check_reset_state("midrst");
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (6) cycle();

        // Randomized traffic with random backpressure against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            logic [63:0] r;
            r    = {$urandom(), $urandom()};
            x.s  = r[63];
            x.e  = 7'($urandom());
            x.st = r[62];
            x.rm = r[61:60];
            x.m  = r[36:0] >> $urandom_range(0, 37);
            if ($urandom_range(0, 7) == 0) x.m = 37'd0;
            drive(x, $urandom_range(0, 3) != 0);
            bus.out_ready = $urandom_range(0, 3) != 0;
            cycle();
        end
        drive('0, 1'b0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) cycle();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain_empty: got %0d results outstanding, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
